// File: rtl/kmul_pkg.sv
// Shared constants for the karatsuba operand sequencer: default width and FSM state codes.
package kmul_pkg;
  localparam int DEF_W  = 32;
  localparam int PROD_W = 2 * DEF_W;

  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t WAIT = 2'd1;
  localparam state_t HOLD = 2'd2;
endpackage

// File: rtl/kmul_op_fifo.sv
// Synchronous operand FIFO; pointers carry an extra wrap bit to tell full from empty.
module kmul_op_fifo
  import kmul_pkg::*;
#(
  parameter int DW    = PROD_W,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]   wr_ptr, rd_ptr;
  logic [DW-1:0] mem [DEPTH];
  logic          do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A pop in the same cycle does not free a slot for a push while full.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/karatsuba_op_seq.sv
// Feeds buffered operand pairs to the multiplier, holds them LAT cycles, and
// returns each product in order on a valid/ready stream.
module karatsuba_op_seq
  import kmul_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int LAT   = 2,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           s_valid,
  output logic           s_ready,
  input  logic [W-1:0]   s_a,
  input  logic [W-1:0]   s_b,
  output logic [W-1:0]   mul_a,
  output logic [W-1:0]   mul_b,
  input  logic [2*W-1:0] mul_p,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [2*W-1:0] m_prod,
  output logic           busy,
  output logic [15:0]    op_count
);
  localparam int PW = 2 * W;
  localparam int CW = $clog2(LAT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(LAT - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [PW-1:0] head;
  logic          fifo_full, fifo_empty;
  logic          pop, done, last;

  assign s_ready = !fifo_full;
  assign done    = m_valid && m_ready;
  assign last    = (cnt == CNT_LAST);
  assign busy    = (state != IDLE) || !fifo_empty;

  kmul_op_fifo #(.DW(PW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (s_valid),
    .pop   (pop),
    .wdata ({s_a, s_b}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (!fifo_empty) state_nxt = WAIT;
      WAIT: if (last) state_nxt = HOLD;
      HOLD: if (m_ready) state_nxt = fifo_empty ? IDLE : WAIT;
      default: state_nxt = IDLE;
    endcase
  end

  // Pop only when the operand register is free: idle, or the held result is leaving.
  always_comb begin
    pop = 1'b0;
    case (state)
      IDLE: pop = !fifo_empty;
      HOLD: pop = m_ready && !fifo_empty;
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a    <= '0;
      mul_b    <= '0;
      cnt      <= '0;
      m_prod   <= '0;
      m_valid  <= 1'b0;
      op_count <= '0;
    end else begin
      if (pop) begin
        {mul_a, mul_b} <= head;
        cnt            <= '0;
      end else if (state == WAIT) begin
        cnt <= cnt + 1'b1;
      end
      if (state == WAIT && last) begin
        m_prod  <= mul_p;
        m_valid <= 1'b1;
      end else if (done) begin
        m_valid <= 1'b0;
      end
      if (done) op_count <= op_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_karatsuba_op_seq.sv
// Self-checking bench for karatsuba_op_seq with a pipelined multiplier stand-in.
module tb_karatsuba_op_seq;
  localparam int W = 32, LAT = 2, DEPTH = 4;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          s_valid = 1'b0, s_ready;
  logic [W-1:0]  s_a = '0, s_b = '0, mul_a, mul_b;
  logic [63:0]   mul_p, mul_q, m_prod;
  logic          m_valid, m_ready = 1'b0, busy;
  logic [15:0]   op_count;

  int checks = 0, failures = 0, cyc = 0;
  logic [63:0] exp_q[$], got_q[$];
  int          got_t[$];

  karatsuba_op_seq #(.W(W), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_a(s_a), .s_b(s_b), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .m_valid(m_valid), .m_ready(m_ready), .m_prod(m_prod),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier stand-in: LAT-1 register stages, so a product is only right LAT edges after loading.
  always @(posedge clk) mul_q <= {32'b0, mul_a} * {32'b0, mul_b};
  assign mul_p = mul_q;

  // Result monitor: logs handshakes and checks that a stalled result and its operands stay put.
  logic        prev_hold = 1'b0;
  logic [63:0] prev_prod;
  logic [W-1:0] prev_a;
  always begin
    @(negedge clk); #1;
    if (prev_hold && rst_n) begin
      checks++;
      if (m_valid !== 1'b1 || m_prod !== prev_prod || mul_a !== prev_a) begin
        failures++;
        $display("FAIL hold_stable m_valid=%0b m_prod=%h mul_a=%h want 1 %h %h",
                 m_valid, m_prod, mul_a, prev_prod, prev_a);
      end
    end
    prev_hold = rst_n && m_valid && !m_ready;
    prev_prod = m_prod;
    prev_a    = mul_a;
    if (rst_n && m_valid && m_ready) begin
      got_q.push_back(m_prod);
      got_t.push_back(cyc);
    end
  end

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    s_valid = 1'b1; s_a = a; s_b = b;
    while (!s_ready && n < 200) begin @(negedge clk); n++; end
    if (!s_ready) begin
      checks++; failures++;
      $display("FAIL push_timeout s_ready=%0b want 1", s_ready);
    end else begin
      exp_q.push_back({32'b0, a} * {32'b0, b});
    end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    int k = 0;
    while (got_q.size() < n && k < 1000) begin @(negedge clk); k++; end
    @(negedge clk);
    checks++;
    if (got_q.size() != n) begin
      failures++;
      $display("FAIL drain_count got=%0d want=%0d", got_q.size(), n);
    end
  endtask

  task automatic clear_q();
    exp_q.delete(); got_q.delete(); got_t.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (mul_a !== 0 || mul_b !== 0 || m_prod !== 0 || m_valid !== 0 ||
        op_count !== 0 || busy !== 0 || s_ready !== 1) begin
      failures++;
      $display("FAIL reset_state a=%h b=%h p=%h v=%b cnt=%0d busy=%b rdy=%b want zeros rdy=1",
               mul_a, mul_b, m_prod, m_valid, op_count, busy, s_ready);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int t0;
    clear_q();
    m_ready = 1'b1;
    s_valid = 1'b1; s_a = 2; s_b = 2;
    t0 = cyc + 1;
    @(negedge clk); s_valid = 1'b0;
    checks++;
    if (mul_a !== 0 || busy !== 1) begin
      failures++; $display("FAIL single_no_fallthrough mul_a=%0d busy=%b want 0 1", mul_a, busy);
    end
    @(negedge clk);
    checks++;
    if (mul_a !== 2 || mul_b !== 2 || m_valid !== 0) begin
      failures++; $display("FAIL single_load a=%0d b=%0d v=%b want 2 2 0", mul_a, mul_b, m_valid);
    end
    repeat (LAT - 1) @(negedge clk);
    checks++;
    if (m_valid !== 0) begin failures++; $display("FAIL single_early v=%b want 0", m_valid); end
    @(negedge clk);
    checks++;
    if (m_valid !== 1 || m_prod !== 64'd4 || cyc != t0 + 1 + LAT) begin
      failures++;
      $display("FAIL single_result v=%b p=%0d cyc=%0d want 1 4 %0d", m_valid, m_prod, cyc, t0 + 1 + LAT);
    end
    @(negedge clk);
    checks++;
    if (op_count !== 16'd1 || m_valid !== 0 || busy !== 0) begin
      failures++; $display("FAIL single_count cnt=%0d v=%b busy=%b want 1 0 0", op_count, m_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] c0 = op_count;
    clear_q();
    m_ready = 1'b1;
    push(20, 10); push(2132, 3212); push(5322, 5652); push(76842, 28654);
    drain(4);
    for (int i = 0; i < 4 && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL b2b_prod[%0d] got=%0d want=%0d", i, got_q[i], exp_q[i]);
      end
      if (i > 0) begin
        checks++;
        if (got_t[i] - got_t[i-1] != LAT + 1) begin
          failures++; $display("FAIL b2b_spacing[%0d] got=%0d want=%0d", i, got_t[i] - got_t[i-1], LAT + 1);
        end
      end
    end
    checks++;
    if (got_q.size() == 4 && got_q[3] !== 64'd2201830668) begin
      failures++; $display("FAIL b2b_last got=%0d want=2201830668", got_q[3]);
    end
    checks++;
    if (op_count !== c0 + 16'd4) begin
      failures++; $display("FAIL b2b_count got=%0d want=%0d", op_count, c0 + 16'd4);
    end
  endtask

  task automatic test_full();
    logic [63:0] p0;
    logic [W-1:0] a0;
    int k = 0;
    clear_q();
    m_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) push($urandom, $urandom);
    checks++;
    if (s_ready !== 0) begin failures++; $display("FAIL full_sready got=%b want 0", s_ready); end
    while (!m_valid && k < 20) begin @(negedge clk); k++; end
    p0 = m_prod; a0 = mul_a;
    repeat (6) @(negedge clk);
    checks++;
    if (m_valid !== 1 || m_prod !== p0 || mul_a !== a0 || p0 !== exp_q[0] || s_ready !== 0) begin
      failures++;
      $display("FAIL full_stall v=%b p=%h a=%h rdy=%b want 1 %h %h 0", m_valid, m_prod, mul_a, s_ready, exp_q[0], a0);
    end
    m_ready = 1'b1;
    drain(DEPTH + 1);
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL full_prod[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_wide();
    clear_q();
    m_ready = 1'b1;
    push(32'd76843552, 32'd28625354);
    push(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    drain(2);
    checks++;
    if (got_q.size() != 2 || got_q[0] !== 64'd2199673878617408 || got_q[1] !== 64'hFFFF_FFFE_0000_0001) begin
      failures++;
      $display("FAIL wide_prod got=%h,%h want=%h,%h", got_q.size() > 0 ? got_q[0] : 64'h0,
               got_q.size() > 1 ? got_q[1] : 64'h0, 64'd2199673878617408, 64'hFFFF_FFFE_0000_0001);
    end
  endtask

  task automatic test_reset_mid_wait();
    clear_q();
    m_ready = 1'b1;
    push($urandom, $urandom); push($urandom, $urandom); push($urandom, $urandom);
    checks++;
    if (busy !== 1 || m_valid !== 0) begin
      failures++; $display("FAIL rst_setup busy=%b v=%b want 1 0", busy, m_valid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (m_valid !== 0 || mul_a !== 0 || op_count !== 0 || busy !== 0 || s_ready !== 1) begin
      failures++;
      $display("FAIL rst_mid v=%b a=%h cnt=%0d busy=%b rdy=%b want 0 0 0 0 1", m_valid, mul_a, op_count, busy, s_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    clear_q();
    repeat (10) @(negedge clk);
    checks++;
    if (got_q.size() != 0 || m_valid !== 0 || busy !== 0) begin
      failures++; $display("FAIL rst_stale results=%0d v=%b busy=%b want 0 0 0", got_q.size(), m_valid, busy);
    end
  endtask

  task automatic test_random();
    logic [15:0] c0 = op_count;
    clear_q();
    fork
      for (int i = 0; i < 25; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        push($urandom, $urandom);
      end
      repeat (150) begin @(negedge clk); m_ready = $urandom_range(0, 1); end
    join
    m_ready = 1'b1;
    drain(25);
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++; $display("FAIL rand_prod[%0d] got=%h want=%h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (op_count !== c0 + 16'd25) begin
      failures++; $display("FAIL rand_count got=%0d want=%0d", op_count, c0 + 16'd25);
    end
  endtask

  task automatic test_wrap();
    clear_q();
    m_ready = 1'b1;
    @(negedge clk);
    force dut.op_count = 16'hFFFF;
    @(negedge clk);
    release dut.op_count;
    @(negedge clk);
    checks++;
    if (op_count !== 16'hFFFF) begin failures++; $display("FAIL wrap_preload got=%h want ffff", op_count); end
    push($urandom, $urandom);
    drain(1);
    repeat (2) @(negedge clk);
    checks++;
    if (op_count !== 16'h0 || busy !== 0 || s_ready !== 1 || (got_q.size() == 1 && got_q[0] !== exp_q[0])) begin
      failures++; $display("FAIL wrap_count cnt=%h busy=%b rdy=%b want 0 0 1", op_count, busy, s_ready);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_wide();
    test_random();
    test_reset_mid_wait();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
